rpc_reg_init_master: RTL

//  Register-bus initiator driving the RPC controller's config slave after reset/start.

---
 rtl/rpc_init_pkg.sv | 26 ++
 rtl/rpc_reg_init_master.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rpc_init_pkg.sv
// Shared types for the RPC register-init initiator: FSM states, error codes
// and default register-bus widths.
package rpc_init_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 48;
    localparam int REG_DATA_WIDTH_DEF = 32;

    // RB is always declared so both builds share one encoding; it is only
    // reachable when the readback option is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RB    = 3'd2,
        ST_POLL  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BUS      = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_READBACK = 2'd3
    } err_code_e;

endpackage

// File: rtl/rpc_reg_init_master.sv
// Register-bus initiator that programs the RPC controller config slave from an
// external (addr,data) table, then polls a status register until ready.
// Optional build macro: RPC_INIT_READBACK_EN -- read back and compare every
// table write before moving to the next entry.
module rpc_reg_init_master
    import rpc_init_pkg::*;
#(
    parameter int NumWrites      = 8,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
    parameter logic [REG_ADDR_WIDTH-1:0] PollAddr = 'h0,
    parameter logic [REG_DATA_WIDTH-1:0] PollMask = 'h1,
    parameter int PollTimeout    = 1024,
    localparam int IDX_W  = (NumWrites > 1) ? $clog2(NumWrites) : 1,
    localparam int CNT_W  = $clog2(PollTimeout + 1),
    localparam int STRB_W = REG_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic [IDX_W-1:0]          tbl_idx_o,
    input  logic [REG_ADDR_WIDTH-1:0] tbl_addr_i,
    input  logic [REG_DATA_WIDTH-1:0] tbl_data_i,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic                      reg_write_o,
    output logic [REG_DATA_WIDTH-1:0] reg_wdata_o,
    output logic [STRB_W-1:0]         reg_wstrb_o,
    output logic                      reg_valid_o,
    input  logic [REG_DATA_WIDTH-1:0] reg_rdata_i,
    input  logic                      reg_ready_i,
    input  logic                      reg_error_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [1:0]                err_code_o
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NumWrites - 1);
    localparam logic [CNT_W-1:0] LAST_POLL = CNT_W'(PollTimeout - 1);

    state_e           state;
    logic [CNT_W-1:0] poll_cnt;

    // Single FSM: each busy state launches one registered request when valid
    // is low, then waits for the handshake, which always leaves one idle cycle
    // before the next request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            tbl_idx_o   <= '0;
            poll_cnt    <= '0;
            reg_addr_o  <= '0;
            reg_write_o <= 1'b0;
            reg_wdata_o <= '0;
            reg_wstrb_o <= '0;
            reg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    reg_valid_o <= 1'b0;
                    if (start_i) begin
                        state      <= ST_WRITE;
                        tbl_idx_o  <= '0;
                        poll_cnt   <= '0;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        error_o    <= 1'b0;
                        err_code_o <= ERR_NONE;
                    end
                end

                ST_WRITE: begin
                    if (!reg_valid_o) begin
                        reg_valid_o <= 1'b1;
                        reg_write_o <= 1'b1;
                        reg_addr_o  <= tbl_addr_i;
                        reg_wdata_o <= tbl_data_i;
                        reg_wstrb_o <= '1;
                    end else if (reg_ready_i) begin
                        reg_valid_o <= 1'b0;
                        reg_write_o <= 1'b0;
                        reg_wstrb_o <= '0;
                        if (reg_error_i) begin
                            state      <= ST_ERROR;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= ERR_BUS;
                        end else begin
`ifdef RPC_INIT_READBACK_EN
                            state <= ST_RB;
`else
                            if (tbl_idx_o == LAST_IDX) begin
                                state <= ST_POLL;
                            end else begin
                                tbl_idx_o <= tbl_idx_o + 1'b1;
                            end
`endif
                        end
                    end
                end

`ifdef RPC_INIT_READBACK_EN
                ST_RB: begin
                    // reg_addr_o still holds the address just written.
                    if (!reg_valid_o) begin
                        reg_valid_o <= 1'b1;
                        reg_write_o <= 1'b0;
                        reg_wstrb_o <= '0;
                    end else if (reg_ready_i) begin
                        reg_valid_o <= 1'b0;
                        if (reg_error_i) begin
                            state      <= ST_ERROR;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= ERR_BUS;
                        end else if (reg_rdata_i != tbl_data_i) begin
                            state      <= ST_ERROR;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= ERR_READBACK;
                        end else if (tbl_idx_o == LAST_IDX) begin
                            state <= ST_POLL;
                        end else begin
                            state     <= ST_WRITE;
                            tbl_idx_o <= tbl_idx_o + 1'b1;
                        end
                    end
                end
`endif

                ST_POLL: begin
                    if (!reg_valid_o) begin
                        reg_valid_o <= 1'b1;
                        reg_write_o <= 1'b0;
                        reg_addr_o  <= PollAddr;
                        reg_wstrb_o <= '0;
                    end else if (reg_ready_i) begin
                        reg_valid_o <= 1'b0;
                        if (reg_error_i) begin
                            state      <= ST_ERROR;
                            busy_o     <= 1'b0;
                            error_o    <= 1'b1;
                            err_code_o <= ERR_BUS;
                        end else if ((reg_rdata_i & PollMask) == PollMask) begin
                            state  <= ST_DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            if (poll_cnt == LAST_POLL) begin
                                state      <= ST_ERROR;
                                busy_o     <= 1'b0;
                                error_o    <= 1'b1;
                                err_code_o <= ERR_TIMEOUT;
                            end
                        end
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    reg_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
